// File: rtl/mips_pkg.sv
// Shared data-memory constants and arbiter types.
// Owner encoding and read-return tracker entry.
package mips_pkg;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam logic [15:0] MMIO_ADDR = 16'hFFFC;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_EXT  = 2'd2
    } owner_e;

    typedef struct packed {
        logic   pending;
        owner_e owner;
    } rd_trk_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive denied external cycles.
// at_limit forces the next contended grant to the external port.
module arb_starve_counter #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    logic [3:0] cnt;

    assign at_limit = (cnt == 4'(LIMIT));

    // clear wins over increment; hold once saturated
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && !at_limit)
            cnt <= cnt + 4'd1;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU priority, bounded external starvation.
// Define DMEM_ARB_MMIO_EN to enable the MMIO output register decode.
module dmem_arbiter
    import mips_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [15:0]   cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic          ext_gnt,
    output logic          ext_rvalid,
    output logic [DW-1:0] ext_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          mmio_valid,
    output logic [DW-1:0] mmio_data,
    output logic          addr_err
);

    logic    cpu_is_mmio;
    logic    cpu_oob;
    logic    cpu_mem_req;
    logic    cpu_mem_gnt;
    logic    at_limit;
    logic    mmio_rd_q;
    owner_e  state_q;
    owner_e  state_d;
    logic    rd_pend_q;
    logic    rd_pend_d;
    rd_trk_t trk;

`ifdef DMEM_ARB_MMIO_EN
    assign cpu_is_mmio = (cpu_addr == MMIO_ADDR);
`else
    assign cpu_is_mmio = 1'b0;
`endif

    assign cpu_oob     = |cpu_addr[15:AW];
    assign cpu_mem_req = cpu_req & ~cpu_is_mmio;

    // MMIO accesses never touch memory, so ext may share the cycle
    assign ext_gnt     = ~reset & ext_req & (~cpu_mem_req | at_limit);
    assign cpu_gnt     = ~reset & cpu_req & (cpu_is_mmio | ~ext_gnt);
    assign cpu_mem_gnt = cpu_gnt & ~cpu_is_mmio;
    assign cpu_stall   = cpu_req & ~cpu_gnt;

    arb_starve_counter #(
        .LIMIT    (STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .inc      (ext_req & ~ext_gnt),
        .clr      (ext_gnt | ~ext_req),
        .at_limit (at_limit)
    );

    // steer the granted memory user onto the array port
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (1'b1)
            ext_gnt: begin
                mem_en    = 1'b1;
                mem_we    = ext_we;
                mem_addr  = ext_addr;
                mem_wdata = ext_wdata;
            end
            cpu_mem_gnt: begin
                mem_en    = 1'b1;
                mem_we    = cpu_we;
                mem_addr  = cpu_addr[AW-1:0];
                mem_wdata = cpu_wdata;
            end
            default: ;
        endcase
    end

    // owner FSM next state and read-pending capture
    always_comb begin
        state_d   = OWN_IDLE;
        rd_pend_d = mem_en & ~mem_we;
        unique case (1'b1)
            ext_gnt:     state_d = OWN_EXT;
            cpu_mem_gnt: state_d = OWN_CPU;
            default:     state_d = OWN_IDLE;
        endcase
    end

    // owner FSM state and tracker pending bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= OWN_IDLE;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    assign trk = '{pending: rd_pend_q, owner: state_q};

    assign cpu_rvalid = (trk.pending && trk.owner == OWN_CPU) | mmio_rd_q;
    assign ext_rvalid = trk.pending && trk.owner == OWN_EXT;
    assign cpu_rdata  = (trk.pending && trk.owner == OWN_CPU) ? mem_rdata : '0;
    assign ext_rdata  = (trk.pending && trk.owner == OWN_EXT) ? mem_rdata : '0;

    // sticky flag for CPU accesses beyond the array that are not MMIO
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            addr_err <= 1'b0;
        else if (cpu_mem_gnt && cpu_oob)
            addr_err <= 1'b1;
    end

`ifdef DMEM_ARB_MMIO_EN
    // MMIO output register and MMIO read acknowledge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mmio_valid <= 1'b0;
            mmio_data  <= '0;
            mmio_rd_q  <= 1'b0;
        end else begin
            mmio_valid <= cpu_gnt & cpu_is_mmio & cpu_we;
            mmio_rd_q  <= cpu_gnt & cpu_is_mmio & ~cpu_we;
            if (cpu_gnt && cpu_is_mmio && cpu_we)
                mmio_data <= cpu_wdata;
        end
    end
`else
    assign mmio_valid = 1'b0;
    assign mmio_data  = '0;
    assign mmio_rd_q  = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 256x16 memory model.
// Build with or without DMEM_ARB_MMIO_EN.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_addr, cpu_wdata;
    logic        cpu_gnt, cpu_stall, cpu_rvalid;
    logic [15:0] cpu_rdata;
    logic        ext_req, ext_we;
    logic [7:0]  ext_addr;
    logic [15:0] ext_wdata;
    logic        ext_gnt, ext_rvalid;
    logic [15:0] ext_rdata;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic        mmio_valid;
    logic [15:0] mmio_data;
    logic        addr_err;

    int errors = 0;
    int checks = 0;

    logic [15:0] mem [256];

    always #5 clk = ~clk;

    dmem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_stall  (cpu_stall),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .ext_req    (ext_req),
        .ext_we     (ext_we),
        .ext_addr   (ext_addr),
        .ext_wdata  (ext_wdata),
        .ext_gnt    (ext_gnt),
        .ext_rvalid (ext_rvalid),
        .ext_rdata  (ext_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mmio_valid (mmio_valid),
        .mmio_data  (mmio_data),
        .addr_err   (addr_err)
    );

    // single-port synchronous memory, one-cycle read latency
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we)
                mem[mem_addr] <= mem_wdata;
            else
                mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic ext_write(input logic [7:0] a, input logic [15:0] d);
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = a; ext_wdata = d;
        #2 chk("load_gnt", ext_gnt, 1);
        tick;
        ext_req = 1'b0; ext_we = 1'b0;
    endtask

    task automatic ext_read(input logic [7:0] a, input logic [15:0] exp,
                            input string tag);
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = a;
        #2 chk({tag, "_gnt"}, ext_gnt, 1);
        tick;
        ext_req = 1'b0;
        chk({tag, "_rvalid"}, ext_rvalid, 1);
        chk({tag, "_rdata"}, ext_rdata, 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_ext;
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ext_req = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0;
        tick; tick;
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_ext_gnt", ext_gnt, 0);
        chk("rst_cpu_rvalid", cpu_rvalid, 0);
        chk("rst_ext_rvalid", ext_rvalid, 0);
        chk("rst_mmio_valid", mmio_valid, 0);
        chk("rst_mmio_data", mmio_data, 0);
        chk("rst_addr_err", addr_err, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_state", 32'(dut.state_q), 0);
        reset = 1'b0;
        tick;

        ext_write(8'd4, 16'h0F00);
        ext_write(8'd1, 16'h1111);
        ext_write(8'd2, 16'h2222);
        ext_write(8'd5, 16'h0505);
        tick;

        // CPU-only read of addr 4
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'd4;
        #2;
        chk("rd4_gnt", cpu_gnt, 1);
        chk("rd4_stall", cpu_stall, 0);
        chk("rd4_mem_en", mem_en, 1);
        chk("rd4_mem_addr", mem_addr, 4);
        tick;
        cpu_req = 0;
        chk("rd4_rvalid", cpu_rvalid, 1);
        chk("rd4_rdata", cpu_rdata, 16'h0F00);
        chk("rd4_ext_rvalid", ext_rvalid, 0);
        tick;

        // continuous contention: ext wins every fifth cycle
        cpu_req = 1; cpu_addr = 16'd1;
        ext_req = 1; ext_we = 0; ext_addr = 8'd2;
        for (int i = 0; i < 10; i++) begin
            exp_ext = (i == 4) || (i == 9);
            #2;
            chk($sformatf("starve%0d_ext", i), ext_gnt, 32'(exp_ext));
            chk($sformatf("starve%0d_cpu", i), cpu_gnt, 32'(!exp_ext));
            chk($sformatf("starve%0d_stall", i), cpu_stall, 32'(exp_ext));
            tick;
        end
        cpu_req = 0; ext_req = 0;
        tick;

        // CPU store to FFFC while ext stores to 7
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'hFFFC; cpu_wdata = 16'd42;
        ext_req = 1; ext_we = 1; ext_addr = 8'd7; ext_wdata = 16'h7777;
        #2;
`ifdef DMEM_ARB_MMIO_EN
        chk("mmio_cpu_gnt", cpu_gnt, 1);
        chk("mmio_ext_gnt", ext_gnt, 1);
        chk("mmio_mem_addr", mem_addr, 7);
        tick;
        cpu_req = 0; cpu_we = 0; ext_req = 0; ext_we = 0;
        chk("mmio_valid", mmio_valid, 1);
        chk("mmio_data", mmio_data, 42);
        chk("mmio_addr_err", addr_err, 0);
        tick;
        chk("mmio_valid_pulse", mmio_valid, 0);
`else
        chk("nommio_cpu_gnt", cpu_gnt, 1);
        chk("nommio_ext_gnt", ext_gnt, 0);
        chk("nommio_mem_addr", mem_addr, 8'hFC);
        tick;
        cpu_req = 0; cpu_we = 0;
        #2 chk("nommio_ext_gnt2", ext_gnt, 1);
        chk("nommio_valid", mmio_valid, 0);
        chk("nommio_addr_err", addr_err, 1);
        tick;
        ext_req = 0; ext_we = 0;
        chk("nommio_data", mmio_data, 0);
        ext_read(8'hFC, 16'd42, "nommio_fc");
`endif
        ext_read(8'd7, 16'h7777, "w7");

        // ext read granted, reset lands before the return edge
        ext_req = 1; ext_we = 0; ext_addr = 8'd2;
        #2 chk("rstrd_gnt", ext_gnt, 1);
        #2 reset = 1'b1;
        #1;
        chk("rstrd_gnt_in_rst", ext_gnt, 0);
        chk("rstrd_mem_en", mem_en, 0);
        tick;
        ext_req = 0;
        chk("rstrd_ext_rvalid", ext_rvalid, 0);
        chk("rstrd_addr_err", addr_err, 0);
        chk("rstrd_mmio_data", mmio_data, 0);
        chk("rstrd_state", 32'(dut.state_q), 0);
        reset = 1'b0;
        tick;
        chk("rstrd_ext_rvalid2", ext_rvalid, 0);
        chk("rstrd_cpu_rvalid2", cpu_rvalid, 0);

        // out-of-range CPU read, sticky error
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0105;
        #2;
        chk("oob_mem_addr", mem_addr, 8'h05);
        chk("oob_err_before", addr_err, 0);
        tick;
        cpu_req = 0;
        chk("oob_err", addr_err, 1);
        chk("oob_rdata", cpu_rdata, 16'h0505);
        for (int i = 0; i < 10; i++) begin
            cpu_req = 1; cpu_addr = 16'(i);
            tick;
            chk($sformatf("oob_sticky%0d", i), addr_err, 1);
        end
        cpu_req = 0;
        tick;

        // alternating reads: cpu addr 1 then ext addr 2
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'd1;
        #2 chk("alt_cpu_gnt", cpu_gnt, 1);
        tick;
        cpu_req = 0;
        ext_req = 1; ext_we = 0; ext_addr = 8'd2;
        chk("alt_cpu_rvalid", cpu_rvalid, 1);
        chk("alt_cpu_rdata", cpu_rdata, 16'h1111);
        chk("alt_ext_rvalid0", ext_rvalid, 0);
        #1 chk("alt_ext_gnt", ext_gnt, 1);
        tick;
        ext_req = 0;
        chk("alt_ext_rvalid", ext_rvalid, 1);
        chk("alt_ext_rdata", ext_rdata, 16'h2222);
        chk("alt_cpu_rvalid1", cpu_rvalid, 0);
        chk("alt_cpu_rdata1", cpu_rdata, 0);
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
